// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide sequencer: radix-2 Booth multiply and restoring
// divide, one bit per cycle, loading HI/LO with a one-cycle done/write pulse.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_write,
  output logic             lo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE, S_DZERO} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH:0]   acc_q, acc_d;   // Booth accumulator, or divide remainder
  logic signed [WIDTH:0]   m_q, m_d;       // sign-extended multiplicand, or divisor magnitude
  logic [WIDTH-1:0]        q_q, q_d;       // multiplier bits, or quotient bits
  logic                    q1_q, q1_d;
  logic                    sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;

  logic signed [WIDTH:0]   booth_sum, acc_n;
  logic [WIDTH-1:0]        q_n;
  logic [WIDTH:0]          div_shift, div_diff;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? WIDTH'(-v) : v;
  endfunction

  always_comb begin
    booth_sum = acc_q;
    case ({q_q[0], q1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
    acc_n     = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    q_n       = {booth_sum[0], q_q[WIDTH-1:1]};
    // Remainder stays below the divisor, so the shifted value always fits WIDTH+1 bits
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_diff  = div_shift - m_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d = S_MULT;
          cnt_d   = '0;
          acc_d   = '0;
          m_d     = {op_a[WIDTH-1], op_a};
          q_d     = op_b;
          q1_d    = 1'b0;
        end else if (start_div) begin
          if (op_b != '0) begin
            state_d = S_DIV;
            cnt_d   = '0;
            acc_d   = '0;
            m_d     = {1'b0, mag(op_b)};
            q_d     = mag(op_a);
            sa_d    = op_a[WIDTH-1];
            sb_d    = op_b[WIDTH-1];
          end else begin
            state_d = S_DZERO;
          end
        end
      end
      S_MULT: begin
        acc_d = acc_n;
        q_d   = q_n;
        q1_d  = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          hi_d    = acc_n[WIDTH-1:0];
          lo_d    = q_n;
        end
      end
      S_DIV: begin
        acc_d = div_diff[WIDTH] ? div_shift : div_diff;
        q_d   = {q_q[WIDTH-2:0], ~div_diff[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        lo_d    = cond_neg(q_q, sa_q ^ sb_q);
        hi_d    = cond_neg(acc_q[WIDTH-1:0], sa_q);
      end
      S_DONE:  state_d = S_IDLE;
      S_DZERO: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = (state_q == S_DZERO);
  assign hi_write = done;
  assign lo_write = done;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic reference model plus a per-cycle output
// monitor, with literal expectations for the reference vectors.
module tb_muldiv_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0, start_div = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done, div_zero, hi_write, lo_write;
  logic [31:0] hi_out, lo_out;

  int          checks = 0, errors = 0;
  logic [31:0] model_hi = '0, model_lo = '0, pend_hi = '0, pend_lo = '0;
  int          done_cnt = 0, dz_cnt = 0;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_write(hi_write), .lo_write(lo_write), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Returns {HI=remainder, LO=quotient}, truncating toward zero
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      chk("hi_write", hi_write, done);
      chk("lo_write", lo_write, done);
      if (done) begin
        chk("hi_result", hi_out, pend_hi);
        chk("lo_result", lo_out, pend_lo);
        model_hi = pend_hi;
        model_lo = pend_lo;
        done_cnt++;
      end else begin
        chk("hi_hold", hi_out, model_hi);
        chk("lo_hold", lo_out, model_lo);
      end
      if (div_zero) dz_cnt++;
    end
  end

  task automatic run(input string name, input bit m, input bit d, input logic [31:0] a,
                     input logic [31:0] b, input int exp_lat, input bit exp_dz, input bit inject);
    int c, d0, z0;
    bit got;
    logic [63:0] r;
    @(negedge clock); #1;
    d0 = done_cnt;
    z0 = dz_cnt;
    if (m) r = model_mult(a, b);
    else if (b == 0) r = {model_hi, model_lo};
    else r = model_div(a, b);
    pend_hi = r[63:32];
    pend_lo = r[31:0];
    start_mult = m; start_div = d; op_a = a; op_b = b;
    @(posedge clock); #1;
    start_mult = 0; start_div = 0; op_a = $urandom; op_b = $urandom | 32'h1;
    c = 0;
    got = 0;
    while (!got && c < 100) begin
      @(negedge clock); #2;
      c++;
      chk({name, "_busy"}, busy, 1'b1);
      if (inject && c == 5) begin
        start_mult = 1; start_div = 1; op_a = 32'd9; op_b = 32'd0;
      end
      if (inject && c == 6) begin
        start_mult = 0; start_div = 0;
      end
      if (done || div_zero) got = 1;
    end
    chk({name, "_latency"}, c, exp_lat);
    chk({name, "_dz"}, div_zero, exp_dz);
    chk({name, "_done"}, done, !exp_dz);
    @(negedge clock); #2;
    chk({name, "_idle"}, busy, 1'b0);
    chk({name, "_ndone"}, done_cnt - d0, exp_dz ? 0 : 1);
    chk({name, "_ndz"}, dz_cnt - z0, exp_dz ? 1 : 0);
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", div_zero, 1'b0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    #2 reset = 1'b0;

    run("mult_7x-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 33, 0, 0);
    chk("lit_hi_7x-3", hi_out, 32'hFFFF_FFFF);
    chk("lit_lo_7x-3", lo_out, 32'hFFFF_FFEB);
    run("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 34, 0, 0);
    chk("lit_lo_-7/2", lo_out, 32'hFFFF_FFFD);
    chk("lit_hi_-7/2", hi_out, 32'hFFFF_FFFF);
    run("div_5/0", 0, 1, 32'd5, 32'd0, 1, 1, 0);
    chk("lit_hi_keep", hi_out, 32'hFFFF_FFFF);
    chk("lit_lo_keep", lo_out, 32'hFFFF_FFFD);
    run("mult_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 33, 0, 0);
    chk("lit_hi_minmin", hi_out, 32'h4000_0000);
    chk("lit_lo_minmin", lo_out, 32'h0);
    run("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0, 0);
    chk("lit_lo_min/-1", lo_out, 32'h8000_0000);
    chk("lit_hi_min/-1", hi_out, 32'h0);
    run("mult_-1x-1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 0);
    run("mult_max_max", 1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 0, 0);
    chk("lit_hi_maxmax", hi_out, 32'h3FFF_FFFF);
    run("mult_max_min", 1, 0, 32'h7FFF_FFFF, 32'h8000_0000, 33, 0, 0);
    chk("lit_lo_maxmin", lo_out, 32'h8000_0000);
    run("div_7/-2", 0, 1, 32'd7, 32'hFFFF_FFFE, 34, 0, 0);
    chk("lit_hi_7/-2", hi_out, 32'd1);
    run("div_-7/-2", 0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34, 0, 0);
    chk("lit_lo_-7/-2", lo_out, 32'd3);
    run("div_100/7", 0, 1, 32'd100, 32'd7, 34, 0, 0);
    run("div_min/max", 0, 1, 32'h8000_0000, 32'h7FFF_FFFF, 34, 0, 0);

    run("both_starts", 1, 1, 32'd6, 32'd7, 33, 0, 1);
    chk("lit_lo_both", lo_out, 32'd42);

    // Abort a divide with reset in its tenth cycle
    @(negedge clock); #1;
    start_div = 1; op_a = 32'd100; op_b = 32'd3;
    @(posedge clock); #1;
    start_div = 0;
    repeat (10) @(negedge clock);
    #2;
    reset = 1'b1;
    model_hi = '0; model_lo = '0; pend_hi = '0; pend_lo = '0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_hi", hi_out, 32'h0);
    chk("abort_lo", lo_out, 32'h0);
    @(negedge clock); #2;
    reset = 1'b0;
    d0 = done_cnt;
    repeat (40) @(negedge clock);
    #2;
    chk("abort_no_done", done_cnt - d0, 0);
    run("mult_3x4", 1, 0, 32'd3, 32'd4, 33, 0, 0);
    chk("lit_lo_3x4", lo_out, 32'd12);
    chk("lit_hi_3x4", hi_out, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
